parking_controller: RTL and testbench

Sequencing controller for the 3-slot parking entry-time buffer. It owns the parking clock and the slot-occupancy map. It serves entry/exit requests through a req/ack handshake and drives the buffer's write/read strobes, Car_Id and current_time. On exit it computes parked duration and fee.

---
 rtl/parking_controller.sv | 196 +++++++++++++++++++
 tb/tb_parking_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_controller.sv
// Sequencing controller for the 3-slot parking entry-time buffer: owns the parking
// clock and occupancy map, serves entry/exit handshakes and computes duration and fee.
module parking_controller #(
  parameter logic [7:0]  RATE    = 8'd2,
  parameter logic [15:0] MIN_FEE = 16'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        entry_req,
  input  logic        exit_req,
  input  logic [1:0]  exit_id,
  output logic        entry_ack,
  output logic        entry_nack,
  output logic [1:0]  assigned_id,
  output logic        exit_ack,
  output logic        exit_nack,
  output logic [7:0]  duration,
  output logic [15:0] fee,
  output logic        busy,
  output logic        full,
  output logic [1:0]  occupancy,
  output logic [7:0]  time_now,
  output logic        buf_write_enable,
  output logic        buf_read_enable,
  output logic [1:0]  buf_car_id,
  output logic [7:0]  buf_current_time,
  input  logic [7:0]  buf_entry_time
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ENTRY_WR  = 3'd1,
    EXIT_RD   = 3'd2,
    EXIT_DONE = 3'd3,
    REJECT    = 3'd4
  } state_t;

  // One-hot mask of a slot id; id 3 maps to no slot.
  function automatic logic [2:0] slot_mask(input logic [1:0] id);
    logic [2:0] m;
    case (id)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] lowest_free(input logic [2:0] occ);
    logic [1:0] id;
    if (!occ[0]) begin
      id = 2'd0;
    end else if (!occ[1]) begin
      id = 2'd1;
    end else begin
      id = 2'd2;
    end
    return id;
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] occ);
    return {1'b0, occ[0]} + {1'b0, occ[1]} + {1'b0, occ[2]};
  endfunction

  state_t      state_r, state_next_s;
  logic [1:0]  slot_r, slot_next_s;
  logic        rej_exit_r, rej_exit_next_s;
  logic [2:0]  occ_r, occ_next_s;
  logic [7:0]  time_r;
  logic [7:0]  duration_r;
  logic [15:0] fee_r;
  logic        entry_ack_r, entry_nack_r, exit_ack_r, exit_nack_r;
  logic [1:0]  assigned_id_r, buf_car_id_r, occupancy_r;
  logic        busy_r, full_r, buf_we_r, buf_re_r;
  logic        exit_hit_s;
  logic [7:0]  dur_s;
  logic [15:0] prod_s, fee_s;

  assign exit_hit_s = |(occ_r & slot_mask(exit_id));
  assign dur_s      = time_r - buf_entry_time;
  assign prod_s     = {8'd0, dur_s} * {8'd0, RATE};
  assign fee_s      = (prod_s < MIN_FEE) ? MIN_FEE : prod_s;

  // Next-state, latched slot and occupancy update.
  always_comb begin
    state_next_s    = state_r;
    slot_next_s     = slot_r;
    rej_exit_next_s = rej_exit_r;
    occ_next_s      = occ_r;
    case (state_r)
      IDLE: begin
        if (exit_req) begin
          if (exit_hit_s) begin
            state_next_s = EXIT_RD;
            slot_next_s  = exit_id;
          end else begin
            state_next_s    = REJECT;
            rej_exit_next_s = 1'b1;
          end
        end else if (entry_req) begin
          if (!(&occ_r)) begin
            state_next_s = ENTRY_WR;
            slot_next_s  = lowest_free(occ_r);
          end else begin
            state_next_s    = REJECT;
            rej_exit_next_s = 1'b0;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ENTRY_WR: begin
        occ_next_s   = occ_r | slot_mask(slot_r);
        state_next_s = IDLE;
      end
      EXIT_RD:   state_next_s = EXIT_DONE;
      EXIT_DONE: begin
        occ_next_s   = occ_r & ~slot_mask(slot_r);
        state_next_s = IDLE;
      end
      REJECT:    state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
  end

  // State, time base and registered outputs; outputs decode the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      slot_r        <= 2'd0;
      rej_exit_r    <= 1'b0;
      occ_r         <= 3'b000;
      time_r        <= 8'd0;
      duration_r    <= 8'd0;
      fee_r         <= 16'd0;
      entry_ack_r   <= 1'b0;
      entry_nack_r  <= 1'b0;
      exit_ack_r    <= 1'b0;
      exit_nack_r   <= 1'b0;
      assigned_id_r <= 2'd0;
      buf_car_id_r  <= 2'd0;
      buf_we_r      <= 1'b0;
      buf_re_r      <= 1'b0;
      busy_r        <= 1'b0;
      full_r        <= 1'b0;
      occupancy_r   <= 2'd0;
    end else begin
      state_r    <= state_next_s;
      slot_r     <= slot_next_s;
      rej_exit_r <= rej_exit_next_s;
      occ_r      <= occ_next_s;
      if (tick) begin
        time_r <= time_r + 8'd1;
      end
      // time_r here is the pre-increment value even when tick is high.
      if (state_r == EXIT_RD) begin
        duration_r <= dur_s;
        fee_r      <= fee_s;
      end
      entry_ack_r  <= (state_next_s == ENTRY_WR);
      entry_nack_r <= (state_next_s == REJECT) && !rej_exit_next_s;
      exit_ack_r   <= (state_next_s == EXIT_DONE);
      exit_nack_r  <= (state_next_s == REJECT) && rej_exit_next_s;
      buf_we_r     <= (state_next_s == ENTRY_WR);
      buf_re_r     <= (state_next_s == EXIT_RD);
      if (state_next_s == ENTRY_WR) begin
        assigned_id_r <= slot_next_s;
      end
      if ((state_next_s == ENTRY_WR) || (state_next_s == EXIT_RD)) begin
        buf_car_id_r <= slot_next_s;
      end
      busy_r      <= (state_next_s != IDLE);
      full_r      <= &occ_next_s;
      occupancy_r <= popcount3(occ_next_s);
    end
  end

  assign entry_ack        = entry_ack_r;
  assign entry_nack       = entry_nack_r;
  assign assigned_id      = assigned_id_r;
  assign exit_ack         = exit_ack_r;
  assign exit_nack        = exit_nack_r;
  assign duration         = duration_r;
  assign fee              = fee_r;
  assign busy             = busy_r;
  assign full             = full_r;
  assign occupancy        = occupancy_r;
  assign time_now         = time_r;
  assign buf_write_enable = buf_we_r;
  assign buf_read_enable  = buf_re_r;
  assign buf_car_id       = buf_car_id_r;
  assign buf_current_time = time_r;

endmodule

// File: tb/tb_parking_controller.sv
// Directed, table-driven bench for parking_controller with a behavioural entry-time buffer.
module tb_parking_controller;

  logic        clk = 1'b0;
  logic        reset, tick, entry_req, exit_req;
  logic [1:0]  exit_id;
  logic        entry_ack, entry_nack, exit_ack, exit_nack;
  logic [1:0]  assigned_id, occupancy, buf_car_id;
  logic [7:0]  duration, time_now, buf_current_time, buf_entry_time;
  logic [15:0] fee;
  logic        busy, full, buf_write_enable, buf_read_enable;
  logic [7:0]  mem [3];

  int tests = 0;
  int fails = 0;
  int exp_time = 0;

  always #5 clk = ~clk;

  parking_controller dut (
    .clk(clk), .reset(reset), .tick(tick), .entry_req(entry_req), .exit_req(exit_req),
    .exit_id(exit_id), .entry_ack(entry_ack), .entry_nack(entry_nack),
    .assigned_id(assigned_id), .exit_ack(exit_ack), .exit_nack(exit_nack),
    .duration(duration), .fee(fee), .busy(busy), .full(full), .occupancy(occupancy),
    .time_now(time_now), .buf_write_enable(buf_write_enable),
    .buf_read_enable(buf_read_enable), .buf_car_id(buf_car_id),
    .buf_current_time(buf_current_time), .buf_entry_time(buf_entry_time)
  );

  // Entry-time buffer: written on the strobe, read combinationally.
  always @(posedge clk) begin
    if (reset) begin
      mem[0] <= 8'd0; mem[1] <= 8'd0; mem[2] <= 8'd0;
    end else if (buf_write_enable && buf_car_id != 2'd3) begin
      mem[buf_car_id] <= buf_current_time;
    end
  end
  assign buf_entry_time = (buf_car_id == 2'd3) ? 8'd0 : mem[buf_car_id];

  typedef struct {
    logic        is_exit;
    logic [1:0]  id;
    int          ticks;
    logic        exp_ack;
    logic [1:0]  exp_id;
    logic [7:0]  exp_dur;
    logic [15:0] exp_fee;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic x, input logic [1:0] id, input int t, input logic a,
                              input logic [1:0] eid, input logic [7:0] d, input logic [15:0] f,
                              input logic [1:0] o);
    vec_t v;
    v.is_exit = x; v.id = id; v.ticks = t; v.exp_ack = a; v.exp_id = eid;
    v.exp_dur = d; v.exp_fee = f; v.exp_occ = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tick_n(input int n);
    if (n > 0) begin
      tick = 1'b1;
      repeat (n) step();
      tick = 1'b0;
      exp_time = (exp_time + n) % 256;
    end
  endtask

  task automatic run_req(input logic is_exit, input logic [1:0] id,
                         output logic got_ack, output logic got_nack, output logic [1:0] got_id,
                         output int lat, output logic wr_seen, output logic rd_seen,
                         output logic [7:0] got_dur, output logic [15:0] got_fee,
                         output logic [7:0] wr_time);
    got_ack = 1'b0; got_nack = 1'b0; got_id = 2'd0; lat = 0; wr_seen = 1'b0;
    rd_seen = 1'b0; got_dur = 8'd0; got_fee = 16'd0; wr_time = 8'd0;
    if (is_exit) begin
      exit_id = id; exit_req = 1'b1;
    end else begin
      entry_req = 1'b1;
    end
    for (int c = 1; c <= 6; c++) begin
      step();
      if (buf_write_enable) begin
        wr_seen = 1'b1; wr_time = buf_current_time;
      end
      if (buf_read_enable) rd_seen = 1'b1;
      if (entry_ack | entry_nack | exit_ack | exit_nack) begin
        lat = c;
        got_ack  = is_exit ? exit_ack : entry_ack;
        got_nack = is_exit ? exit_nack : entry_nack;
        got_id = assigned_id; got_dur = duration; got_fee = fee;
        break;
      end
    end
    entry_req = 1'b0; exit_req = 1'b0;
    step();
  endtask

  initial begin
    logic        a, n, ws, rs;
    logic [1:0]  gid;
    logic [7:0]  gd, wt;
    logic [15:0] gf;
    int          lat;

    vecs[0]  = mk(1'b0, 2'd0, 0,   1'b1, 2'd0, 8'd0,  16'd0,  2'd1);
    vecs[1]  = mk(1'b0, 2'd0, 0,   1'b1, 2'd1, 8'd0,  16'd0,  2'd2);
    vecs[2]  = mk(1'b0, 2'd0, 0,   1'b1, 2'd2, 8'd0,  16'd0,  2'd3);
    vecs[3]  = mk(1'b0, 2'd0, 0,   1'b0, 2'd0, 8'd0,  16'd0,  2'd3);
    vecs[4]  = mk(1'b1, 2'd1, 5,   1'b1, 2'd0, 8'd5,  16'd10, 2'd2);
    vecs[5]  = mk(1'b1, 2'd3, 0,   1'b0, 2'd0, 8'd0,  16'd0,  2'd2);
    vecs[6]  = mk(1'b1, 2'd1, 0,   1'b0, 2'd0, 8'd0,  16'd0,  2'd2);
    vecs[7]  = mk(1'b0, 2'd0, 0,   1'b1, 2'd1, 8'd0,  16'd0,  2'd3);
    vecs[8]  = mk(1'b1, 2'd0, 5,   1'b1, 2'd0, 8'd10, 16'd20, 2'd2);
    vecs[9]  = mk(1'b1, 2'd2, 0,   1'b1, 2'd0, 8'd10, 16'd20, 2'd1);
    vecs[10] = mk(1'b1, 2'd1, 0,   1'b1, 2'd0, 8'd5,  16'd10, 2'd0);
    vecs[11] = mk(1'b0, 2'd0, 0,   1'b1, 2'd0, 8'd0,  16'd0,  2'd1);
    vecs[12] = mk(1'b1, 2'd0, 20,  1'b1, 2'd0, 8'd20, 16'd40, 2'd0);
    vecs[13] = mk(1'b0, 2'd0, 220, 1'b1, 2'd0, 8'd0,  16'd0,  2'd1);
    vecs[14] = mk(1'b1, 2'd0, 10,  1'b1, 2'd0, 8'd10, 16'd20, 2'd0);
    vecs[15] = mk(1'b0, 2'd0, 0,   1'b1, 2'd0, 8'd0,  16'd0,  2'd1);
    vecs[16] = mk(1'b1, 2'd0, 0,   1'b1, 2'd0, 8'd0,  16'd1,  2'd0);

    reset = 1'b1; tick = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_id = 2'd0;
    repeat (2) step();
    reset = 1'b0;
    chk("reset_outputs", {entry_ack, entry_nack, exit_ack, exit_nack, busy, full,
                          buf_write_enable, buf_read_enable}, 32'd0);
    chk("reset_occ", occupancy, 32'd0);
    chk("reset_time", time_now, 32'd0);
    chk("reset_dur_fee", {duration, fee}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      tick_n(vecs[i].ticks);
      chk($sformatf("v%0d_time", i), time_now, exp_time);
      run_req(vecs[i].is_exit, vecs[i].id, a, n, gid, lat, ws, rs, gd, gf, wt);
      chk($sformatf("v%0d_ack", i), a, vecs[i].exp_ack);
      chk($sformatf("v%0d_nack", i), n, !vecs[i].exp_ack);
      chk($sformatf("v%0d_latency", i), lat, (vecs[i].exp_ack && vecs[i].is_exit) ? 2 : 1);
      if (!vecs[i].exp_ack) begin
        chk($sformatf("v%0d_no_strobe", i), {ws, rs}, 32'd0);
      end else if (vecs[i].is_exit) begin
        chk($sformatf("v%0d_rd_strobe", i), {ws, rs}, 32'd1);
        chk($sformatf("v%0d_duration", i), gd, vecs[i].exp_dur);
        chk($sformatf("v%0d_fee", i), gf, vecs[i].exp_fee);
      end else begin
        chk($sformatf("v%0d_wr_strobe", i), {ws, rs}, 32'd2);
        chk($sformatf("v%0d_assigned_id", i), gid, vecs[i].exp_id);
        chk($sformatf("v%0d_wr_time", i), wt, exp_time);
      end
      chk($sformatf("v%0d_occupancy", i), occupancy, vecs[i].exp_occ);
      chk($sformatf("v%0d_full", i), full, vecs[i].exp_occ == 2'd3);
      chk($sformatf("v%0d_busy", i), busy, 32'd0);
    end

    // Full lot, simultaneous entry and exit(1): exit first, entry then gets slot 1.
    for (int k = 0; k < 3; k++) run_req(1'b0, 2'd0, a, n, gid, lat, ws, rs, gd, gf, wt);
    chk("sim_prefull", full, 32'd1);
    entry_req = 1'b1; exit_req = 1'b1; exit_id = 2'd1;
    step();
    chk("sim_exit_first", {buf_read_enable, entry_ack, entry_nack}, 32'd4);
    step();
    chk("sim_exit_ack", exit_ack, 32'd1);
    chk("sim_fee_min", fee, 32'd1);
    exit_req = 1'b0;
    step();
    chk("sim_occ_after_exit", occupancy, 32'd2);
    step();
    chk("sim_entry_ack", {entry_ack, assigned_id}, 32'd5);
    entry_req = 1'b0;
    step();
    chk("sim_refull", {full, occupancy}, 32'd7);

    // Reset while in EXIT_RD aborts with no ack.
    tick_n(3);
    exit_req = 1'b1; exit_id = 2'd0;
    step();
    chk("rst_in_exit_rd", buf_read_enable, 32'd1);
    reset = 1'b1; exit_req = 1'b0;
    step();
    reset = 1'b0; exp_time = 0;
    chk("rst_abort", {exit_ack, busy, full, buf_read_enable}, 32'd0);
    chk("rst_abort_occ", occupancy, 32'd0);
    chk("rst_abort_time", time_now, 32'd0);
    step();
    chk("rst_abort_idle", {exit_ack, busy}, 32'd0);

    // Tick during EXIT_RD: duration uses pre-increment time.
    run_req(1'b0, 2'd0, a, n, gid, lat, ws, rs, gd, gf, wt);
    chk("tick_rd_entry", {a, gid}, 32'd4);
    tick = 1'b1; exit_req = 1'b1; exit_id = 2'd0;
    step();
    step();
    tick = 1'b0;
    chk("tick_rd_ack", exit_ack, 32'd1);
    chk("tick_rd_duration", duration, 32'd1);
    chk("tick_rd_fee", fee, 32'd2);
    chk("tick_rd_time", time_now, 32'd2);
    exit_req = 1'b0;
    step();
    chk("tick_rd_occ", occupancy, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
